// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract unit whose carry chain is split into STAGES registered
// chunks, with a valid/ready handshake and carry, overflow and zero flags.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb,
                                 input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Per-stage registers: the whole beat travels together so that lower result
  // chunks and the not-yet-added upper operand chunks stay aligned.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  logic             cy_q  [STAGES];

  logic             v_s [STAGES];
  logic [WIDTH-1:0] a_s [STAGES];
  logic [WIDTH-1:0] b_s [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             c_s [STAGES];

  logic [CW:0]      csum_d [STAGES];
  logic [WIDTH-1:0] res_d  [STAGES];

  logic advance;

  // One global advance: every stage, bubbles included, moves or holds together.
  assign advance  = !vld_q[LAST] || out_ready;
  assign in_ready = advance;

  // Stage sources: stage 0 takes the inverted B and carry for subtraction,
  // later stages take the previous stage's registers.
  always_comb begin
    v_s[0] = in_valid;
    a_s[0] = A;
    b_s[0] = B ^ {WIDTH{sub}};
    c_s[0] = Cin ^ sub;
    r_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_s[k] = vld_q[k-1];
      a_s[k] = opa_q[k-1];
      b_s[k] = opb_q[k-1];
      c_s[k] = cy_q[k-1];
      r_s[k] = res_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      csum_d[k] = {1'b0, a_s[k][k*CW +: CW]} + {1'b0, b_s[k][k*CW +: CW]}
                + {{CW{1'b0}}, c_s[k]};
      res_d[k]  = r_s[k];
      res_d[k][k*CW +: CW] = csum_d[k][CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_s[k];
        opa_q[k] <= a_s[k];
        opb_q[k] <= b_s[k];
        res_q[k] <= res_d[k];
        cy_q[k]  <= csum_d[k][CW];
      end
    end
  end

  // Output stage: everything derives from the last stage's registers.
  assign out_valid = vld_q[LAST];
  assign Sum       = res_q[LAST];
  assign Cout      = cy_q[LAST];
  assign ovf       = ovf_f(opa_q[LAST][WIDTH-1], opb_q[LAST][WIDTH-1],
                           res_q[LAST][WIDTH-1]);
  assign zero      = (res_q[LAST] == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed and random beats against an arithmetic
// reference with a slot-level model of the stall/bubble behaviour.
module tb_pipelined_add_sub;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk, rst, in_valid, in_ready, Cin, sub, out_valid, out_ready;
  logic [W-1:0] A, B, Sum;
  logic         Cout, ovf, zero;

  int vectors    = 0;
  int miscompares = 0;

  bit           mv [S];
  logic [W-1:0] ms [S];
  logic         mc [S];
  logic         mo [S];
  bit           acc;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned for Sum/Cout, signed range for ovf.
  function automatic void ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s,
                                   output logic [W-1:0] sum, output logic co,
                                   output logic ov);
    int ua, ub, sa, sb, ci, r, rs;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(c);
    if (!s) begin
      r  = ua + ub + ci;
      rs = sa + sb + ci;
      co = (r > 65535);
    end else begin
      r  = ua - ub - ci;
      rs = sa - sb - ci;
      co = (r >= 0);
    end
    sum = r[W-1:0];
    ov  = (rs > 32767) || (rs < -32768);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < S; k++) begin
      mv[k] = 1'b0;
      ms[k] = '0;
      mc[k] = 1'b0;
      mo[k] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk16({tag, "_sum"}, Sum, 16'h0000);
    chk1({tag, "_cout"}, Cout, 1'b0);
    chk1({tag, "_ovf"}, ovf, 1'b0);
    chk1({tag, "_zero"}, zero, 1'b1);
  endtask

  // Entered and left at posedge+1: drive, check, clock, advance the model.
  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb, input logic ordy);
    logic         adv;
    logic [W-1:0] es;
    logic         ec, eo;
    in_valid  = iv;
    A         = a;
    B         = b;
    Cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    adv = !mv[S-1] || ordy;
    chk1("in_ready", in_ready, adv);
    chk1("out_valid", out_valid, mv[S-1]);
    if (mv[S-1]) begin
      chk16("sum", Sum, ms[S-1]);
      chk1("cout", Cout, mc[S-1]);
      chk1("ovf", ovf, mo[S-1]);
      chk1("zero", zero, ms[S-1] == '0);
    end
    @(posedge clk);
    acc = iv && adv;
    if (adv) begin
      for (int k = S - 1; k > 0; k--) begin
        mv[k] = mv[k-1];
        ms[k] = ms[k-1];
        mc[k] = mc[k-1];
        mo[k] = mo[k-1];
      end
      ref_calc(a, b, ci, sb, es, ec, eo);
      mv[0] = iv;
      ms[0] = es;
      mc[0] = ec;
      mo[0] = eo;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [W-1:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
  logic [W-1:0] tb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0010};
  logic         tc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0; acc = 1'b0;
    clear_model();
    #3;
    chk_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("post_rst");

    // First beat: zero operands, result visible three edges after acceptance.
    cycle(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Carry ripple, overflow, borrow and zero cases back to back.
    for (int i = 0; i < 5; i++) cycle(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1);
    idle(5);

    // Backpressure: eight beats A=B=i, out_ready low for five cycles.
    begin
      int i = 1;
      int cyc = 0;
      while (i <= 8 && cyc < 60) begin
        cycle(1'b1, 16'(i), 16'(i), 1'b0, 1'b0, !(cyc >= 4 && cyc < 9));
        if (acc) i++;
        cyc++;
      end
      chk16("bp_all_accepted", 16'(i), 16'd9);
    end
    idle(6);

    // Bubbles: in_valid alternating.
    for (int i = 0; i < 8; i++)
      cycle(i % 2 == 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    idle(5);

    // Random traffic with random backpressure.
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    idle(6);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    clear_model();
    @(posedge clk); #1;
    chk_reset("mid_rst_hold");
    rst = 1'b0;
    cycle(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
